store_lane_packer: RTL and testbench

//  Store-side counterpart of the immediate/load extender: narrows a 32-bit register value to a

---
 rtl/store_lane_packer_pkg.sv | 38 +++
 rtl/store_lane_packer_if.sv | 23 ++
 rtl/store_lane_packer_lane_shifter.sv | 29 ++
 rtl/store_lane_packer.sv | 137 +++++++++++++
 tb/tb_store_lane_packer.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/store_lane_packer_pkg.sv
// Shared types for the store lane packer: size encodings, FSM states, lane mask helper.
// MISALIGN_SPLIT_EN adds the SPLIT state used to issue word-crossing stores as two beats.
package store_pkg;

    localparam int DATA_W    = 32;
    localparam int NUM_LANES = DATA_W / 8;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

`ifdef MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HOLD  = 2'b01,
        ST_SPLIT = 2'b10
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HOLD = 2'b01
    } state_e;
`endif

    // Lane mask of a store placed at offset 0; reserved sizes enable nothing.
    function automatic logic [NUM_LANES-1:0] base_mask(input size_e size);
        case (size)
            SZ_BYTE: base_mask = 4'b0001;
            SZ_HALF: base_mask = 4'b0011;
            SZ_WORD: base_mask = 4'b1111;
            default: base_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_packer_if.sv
// Request (EX/MEM side) and beat (data-memory side) handshake bundles for the store lane packer.
interface store_in_if #(parameter int ADDR_W = 32);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [31:0]       in_data;
    logic [1:0]        in_size;

    modport master (output in_valid, in_addr, in_data, in_size, input in_ready);
    modport slave  (input in_valid, in_addr, in_data, in_size, output in_ready);
endinterface

interface store_out_if #(parameter int ADDR_W = 32);
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [31:0]       out_wdata;
    logic [3:0]        out_be;
    logic              out_last;

    modport master (output out_valid, out_addr, out_wdata, out_be, out_last, input out_ready);
    modport slave  (input out_valid, out_addr, out_wdata, out_be, out_last, output out_ready);
endinterface

// File: rtl/store_lane_packer_lane_shifter.sv
// Combinational lane placement: masks the register value to the store size and shifts data
// and byte enables across a 64-bit / 7-lane window so word-crossing stores stay visible.
module lane_shifter
    import store_pkg::*;
(
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic [31:0] data,
    output logic [6:0]  be_full,
    output logic [63:0] wdata_full,
    output logic        crosses
);

    logic [3:0]  mask;
    logic [31:0] data_masked;

    // NOTE: every output of a combinational block is assigned before any branch, so no latch is inferred.
    always_comb begin
        mask        = base_mask(size);
        data_masked = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            data_masked[8*i +: 8] = mask[i] ? data[8*i +: 8] : 8'h00;
        end
        be_full    = {3'b000, mask} << off;
        wdata_full = {32'h0, data_masked} << {off, 3'b000};
        crosses    = |be_full[6:4];
    end

endmodule

// File: rtl/store_lane_packer.sv
// Store lane packer: one registered stage turning a sized store into word-aligned memory beats.
// MISALIGN_SPLIT_EN: word-crossing stores are issued as two beats instead of being dropped.
module store_lane_packer
    import store_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    store_in_if.slave  req,
    store_out_if.master rsp,
    output logic      err_misalign,
    output logic      err_size
);

    state_e            state_q, state_d;
    logic              accept, is_rsvd, load_beat0;
    logic [6:0]        be_full;
    logic [63:0]       wdata_full;
    logic              crosses;
    logic [ADDR_W-1:0] word_addr;
    size_e             size_in;

    assign size_in   = size_e'(req.in_size);
    assign is_rsvd   = (size_in == SZ_RSVD);
    assign word_addr = {req.in_addr[ADDR_W-1:2], 2'b00};
    assign accept    = req.in_valid & req.in_ready;

    lane_shifter u_lane_shifter (
        .off        (req.in_addr[1:0]),
        .size       (size_in),
        .data       (req.in_data),
        .be_full    (be_full),
        .wdata_full (wdata_full),
        .crosses    (crosses)
    );

`ifdef MISALIGN_SPLIT_EN
    logic              load_beat1;
    logic [ADDR_W-1:0] park_addr;
    logic [31:0]       park_wdata;
    logic [3:0]        park_be;
`else
    logic unused_hi_lanes;
    assign unused_hi_lanes = ^{wdata_full[63:32], be_full[6:4]};
`endif

    always_comb begin
        state_d      = state_q;
        load_beat0   = 1'b0;
        req.in_ready = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && rsp.out_ready);
`ifdef MISALIGN_SPLIT_EN
        load_beat1   = 1'b0;
`endif
        if (accept) begin
            // Reserved sizes and (without splitting) crossing stores are consumed silently.
            if (is_rsvd) begin
                state_d = ST_IDLE;
            end else if (crosses) begin
`ifdef MISALIGN_SPLIT_EN
                state_d    = ST_SPLIT;
                load_beat0 = 1'b1;
`else
                state_d    = ST_IDLE;
`endif
            end else begin
                state_d    = ST_HOLD;
                load_beat0 = 1'b1;
            end
        end else begin
            case (state_q)
                ST_HOLD: if (rsp.out_ready) state_d = ST_IDLE;
`ifdef MISALIGN_SPLIT_EN
                ST_SPLIT: if (rsp.out_ready) begin
                    state_d    = ST_HOLD;
                    load_beat1 = 1'b1;
                end
`endif
                default: state_d = state_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp.out_addr  <= '0;
            rsp.out_wdata <= '0;
            rsp.out_be    <= '0;
            rsp.out_last  <= 1'b0;
            err_size      <= 1'b0;
            err_misalign  <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
            park_addr     <= '0;
            park_wdata    <= '0;
            park_be       <= '0;
`endif
        end else begin
            err_size <= accept & is_rsvd;
`ifdef MISALIGN_SPLIT_EN
            err_misalign <= 1'b0;
`else
            err_misalign <= accept & ~is_rsvd & crosses;
`endif
            if (load_beat0) begin
                rsp.out_addr  <= word_addr;
                rsp.out_wdata <= wdata_full[31:0];
                rsp.out_be    <= be_full[3:0];
                rsp.out_last  <= ~crosses;
`ifdef MISALIGN_SPLIT_EN
                park_addr     <= word_addr + ADDR_W'(4);
                park_wdata    <= wdata_full[63:32];
                park_be       <= {1'b0, be_full[6:4]};
`endif
            end
`ifdef MISALIGN_SPLIT_EN
            if (load_beat1) begin
                rsp.out_addr  <= park_addr;
                rsp.out_wdata <= park_wdata;
                rsp.out_be    <= park_be;
                rsp.out_last  <= 1'b1;
            end
`endif
        end
    end

    assign rsp.out_valid = (state_q != ST_IDLE);

endmodule

// File: tb/tb_store_lane_packer.sv
// Directed self-checking bench for store_lane_packer; follows MISALIGN_SPLIT_EN like the RTL.
module tb_store_lane_packer;

    logic clk = 1'b0;
    logic rst_n;
    logic err_misalign, err_size;
    int   checks = 0;
    int   errors = 0;

    store_in_if  #(.ADDR_W(32)) req_if ();
    store_out_if #(.ADDR_W(32)) rsp_if ();

    store_lane_packer #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req_if),
        .rsp          (rsp_if),
        .err_misalign (err_misalign),
        .err_size     (err_size)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_beat(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input logic last);
        check({tag, "_valid"}, 64'(rsp_if.out_valid), 64'(1));
        check({tag, "_addr"},  64'(rsp_if.out_addr),  64'(addr));
        check({tag, "_wdata"}, 64'(rsp_if.out_wdata), 64'(wdata));
        check({tag, "_be"},    64'(rsp_if.out_be),    64'(be));
        check({tag, "_last"},  64'(rsp_if.out_last),  64'(last));
    endtask

    // Presents one request at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] size);
        @(negedge clk);
        req_if.in_valid = 1'b1;
        req_if.in_addr  = addr;
        req_if.in_data  = data;
        req_if.in_size  = size;
        check({tag, "_in_ready"}, 64'(req_if.in_ready), 64'(1));
        @(negedge clk);
        req_if.in_valid = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        req_if.in_valid  = 1'b0;
        req_if.in_addr   = '0;
        req_if.in_data   = '0;
        req_if.in_size   = 2'b00;
        rsp_if.out_ready = 1'b1;

        #2;
        check("rst_in_ready",  64'(req_if.in_ready),  64'(1));
        check("rst_out_valid", 64'(rsp_if.out_valid), 64'(0));
        check("rst_out_addr",  64'(rsp_if.out_addr),  64'(0));
        check("rst_out_wdata", 64'(rsp_if.out_wdata), 64'(0));
        check("rst_out_be",    64'(rsp_if.out_be),    64'(0));
        check("rst_out_last",  64'(rsp_if.out_last),  64'(0));
        check("rst_err_mis",   64'(err_misalign),     64'(0));
        check("rst_err_size",  64'(err_size),         64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Byte and half placed in their lanes, unused lanes zero.
        issue("byte", 32'h0000_1003, 32'h0000_00AB, 2'b00);
        check_beat("byte", 32'h0000_1000, 32'hAB00_0000, 4'b1000, 1'b1);
        issue("half", 32'h0000_2002, 32'h0000_1234, 2'b01);
        check_beat("half", 32'h0000_2000, 32'h1234_0000, 4'b1100, 1'b1);
        issue("bytemask", 32'h0000_6000, 32'hFFFF_FF7E, 2'b00);
        check_beat("bytemask", 32'h0000_6000, 32'h0000_007E, 4'b0001, 1'b1);
        @(negedge clk);
        check("idle_after_beat", 64'(rsp_if.out_valid), 64'(0));

        // Word crossing a word boundary.
        issue("word_mis", 32'h0000_3001, 32'hAABB_CCDD, 2'b10);
`ifdef MISALIGN_SPLIT_EN
        check_beat("split_b0", 32'h0000_3000, 32'hBBCC_DD00, 4'b1110, 1'b0);
        check("split_in_ready", 64'(req_if.in_ready), 64'(0));
        check("split_err_mis", 64'(err_misalign), 64'(0));
        @(negedge clk);
        check_beat("split_b1", 32'h0000_3004, 32'h0000_00AA, 4'b0001, 1'b1);
        @(negedge clk);
        check("split_done", 64'(rsp_if.out_valid), 64'(0));
`else
        check("mis_err_pulse", 64'(err_misalign), 64'(1));
        check("mis_no_beat", 64'(rsp_if.out_valid), 64'(0));
        @(negedge clk);
        check("mis_err_clear", 64'(err_misalign), 64'(0));
        check("mis_still_idle", 64'(rsp_if.out_valid), 64'(0));
`endif

        // Half at offset 3 also crosses.
        issue("half_mis", 32'h0000_5003, 32'h0000_5566, 2'b01);
`ifdef MISALIGN_SPLIT_EN
        check_beat("hsplit_b0", 32'h0000_5000, 32'h6600_0000, 4'b1000, 1'b0);
        @(negedge clk);
        check_beat("hsplit_b1", 32'h0000_5004, 32'h0000_0055, 4'b0001, 1'b1);
        @(negedge clk);
`else
        check("hmis_err_pulse", 64'(err_misalign), 64'(1));
        check("hmis_no_beat", 64'(rsp_if.out_valid), 64'(0));
        @(negedge clk);
`endif

        // Backpressure: beat held stable, a waiting request is not taken.
        rsp_if.out_ready = 1'b0;
        issue("bp", 32'h0000_7000, 32'hCAFE_F00D, 2'b10);
        req_if.in_valid = 1'b1;
        req_if.in_addr  = 32'h0000_8001;
        req_if.in_data  = 32'h0000_0011;
        req_if.in_size  = 2'b00;
        for (int i = 0; i < 3; i++) begin
            check_beat("bp_hold", 32'h0000_7000, 32'hCAFE_F00D, 4'b1111, 1'b1);
            check("bp_in_ready", 64'(req_if.in_ready), 64'(0));
            @(negedge clk);
        end
        rsp_if.out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(req_if.in_ready), 64'(1));
        @(negedge clk);
        check_beat("b2b_0", 32'h0000_8000, 32'h0000_1100, 4'b0010, 1'b1);
        req_if.in_addr = 32'h0000_9000;
        req_if.in_data = 32'h0000_BEEF;
        req_if.in_size = 2'b01;
        check("b2b_in_ready", 64'(req_if.in_ready), 64'(1));
        @(negedge clk);
        req_if.in_valid = 1'b0;
        check_beat("b2b_1", 32'h0000_9000, 32'h0000_BEEF, 4'b0011, 1'b1);
        @(negedge clk);
        check("b2b_drained", 64'(rsp_if.out_valid), 64'(0));

        // Reserved size consumed with an error pulse, then normal traffic resumes.
        issue("rsvd", 32'h0000_4000, 32'h1234_5678, 2'b11);
        check("rsvd_err_pulse", 64'(err_size), 64'(1));
        check("rsvd_no_beat", 64'(rsp_if.out_valid), 64'(0));
        @(negedge clk);
        check("rsvd_err_clear", 64'(err_size), 64'(0));
        issue("after_rsvd", 32'h0000_4002, 32'h0000_005A, 2'b00);
        check_beat("after_rsvd", 32'h0000_4000, 32'h005A_0000, 4'b0100, 1'b1);
        @(negedge clk);

        // Reset with a beat pending: nothing stale survives.
        rsp_if.out_ready = 1'b0;
`ifdef MISALIGN_SPLIT_EN
        issue("pre_rst", 32'h0000_A002, 32'h0102_0304, 2'b10);
        check_beat("pre_rst", 32'h0000_A000, 32'h0304_0000, 4'b1100, 1'b0);
`else
        issue("pre_rst", 32'h0000_A000, 32'h0102_0304, 2'b10);
        check_beat("pre_rst", 32'h0000_A000, 32'h0102_0304, 4'b1111, 1'b1);
`endif
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(rsp_if.out_valid), 64'(0));
        check("mid_rst_ready", 64'(req_if.in_ready), 64'(1));
        check("mid_rst_be", 64'(rsp_if.out_be), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        rsp_if.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("post_rst_valid", 64'(rsp_if.out_valid), 64'(0));
            check("post_rst_ready", 64'(req_if.in_ready), 64'(1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
